// File: rtl/reg_wb_ctrl.sv
// Writeback initiator: buffers ALU/load results in a FIFO and drains one per cycle to the
// register file write port. Define WB_FWD_EN to build the pending-write forwarding lookup.
module reg_wb_ctrl #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alu_valid,
    input  logic [ADDR_W-1:0]        alu_rd,
    input  logic [DATA_W-1:0]        alu_data,
    output logic                     alu_ready,
    input  logic                     mem_valid,
    input  logic [ADDR_W-1:0]        mem_rd,
    input  logic [DATA_W-1:0]        mem_data,
    output logic                     mem_ready,
    input  logic                     wb_stall,
    output logic [ADDR_W-1:0]        write_reg,
    output logic [DATA_W-1:0]        write_data,
    output logic                     RegWrite,
    output logic [$clog2(DEPTH):0]   pending,
    input  logic [ADDR_W-1:0]        fwd_reg,
    output logic                     fwd_hit,
    output logic [DATA_W-1:0]        fwd_data
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] rd_q   [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]  head_q, tail_q;
    logic [CNT_W-1:0]  count_q;

    logic              full, empty, push, pop;
    logic [ADDR_W-1:0] push_rd;
    logic [DATA_W-1:0] push_data;

    // full is taken from the registered count, so a same-cycle pop never frees a slot early
    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign mem_ready = !full;
    assign alu_ready = !full && !mem_valid;
    assign push      = (mem_valid && mem_ready) || (alu_valid && alu_ready);
    assign pop       = !empty && !wb_stall;
    assign push_rd   = mem_valid ? mem_rd : alu_rd;
    assign push_data = mem_valid ? mem_data : alu_data;
    assign pending   = count_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            RegWrite   <= 1'b0;
            write_reg  <= '0;
            write_data <= '0;
        end else begin
            if (push) begin
                rd_q[tail_q]   <= push_rd;
                data_q[tail_q] <= push_data;
                tail_q         <= tail_q + PTR_W'(1);
            end
            if (pop) begin
                write_reg  <= rd_q[head_q];
                write_data <= data_q[head_q];
                head_q     <= head_q + PTR_W'(1);
            end
            RegWrite <= pop;
            count_q  <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

`ifdef WB_FWD_EN
    logic [PTR_W-1:0] fwd_idx;

    // Scan oldest to youngest so the last match seen is the newest pending write
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = '0;
        if (RegWrite && (write_reg == fwd_reg)) begin
            fwd_hit  = 1'b1;
            fwd_data = write_data;
        end
        for (int unsigned i = 0; i < DEPTH; i++) begin
            fwd_idx = head_q + PTR_W'(i);
            if ((CNT_W'(i) < count_q) && (rd_q[fwd_idx] == fwd_reg)) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[fwd_idx];
            end
        end
    end
`else
    logic unused_fwd_reg;
    assign unused_fwd_reg = ^fwd_reg;
    assign fwd_hit        = 1'b0;
    assign fwd_data       = '0;
`endif

endmodule

// File: tb/tb_reg_wb_ctrl.sv
// Directed table-driven bench for reg_wb_ctrl, plus a forwarding sequence.
module tb_reg_wb_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, mem_valid, wb_stall;
    logic [4:0]  alu_rd, mem_rd, fwd_reg;
    logic [63:0] alu_data, mem_data;
    logic        alu_ready, mem_ready, RegWrite, fwd_hit;
    logic [4:0]  write_reg;
    logic [63:0] write_data, fwd_data;
    logic [2:0]  pending;

    int total = 0;
    int bad   = 0;

`ifdef WB_FWD_EN
    localparam bit Fwd = 1'b1;
`else
    localparam bit Fwd = 1'b0;
`endif

    always #5 clk = ~clk;

    reg_wb_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .alu_valid  (alu_valid),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .alu_ready  (alu_ready),
        .mem_valid  (mem_valid),
        .mem_rd     (mem_rd),
        .mem_data   (mem_data),
        .mem_ready  (mem_ready),
        .wb_stall   (wb_stall),
        .write_reg  (write_reg),
        .write_data (write_data),
        .RegWrite   (RegWrite),
        .pending    (pending),
        .fwd_reg    (fwd_reg),
        .fwd_hit    (fwd_hit),
        .fwd_data   (fwd_data)
    );

    typedef struct {
        logic        rst, stall, av;
        logic [4:0]  ard;
        logic [63:0] ad;
        logic        mv;
        logic [4:0]  mrd;
        logic [63:0] md;
        logic        chk_rdy, ar, mr;
        logic        we;
        logic [4:0]  wr;
        logic [63:0] wd;
        logic [2:0]  pend;
    } vec_t;

    vec_t vecs[28];

    function automatic vec_t mk(logic r, logic s, logic av, logic [4:0] ard, logic [63:0] ad,
                                logic mv, logic [4:0] mrd, logic [63:0] md, logic cr,
                                logic ar, logic mr, logic we, logic [4:0] wr,
                                logic [63:0] wd, logic [2:0] pend);
        vec_t v;
        v.rst = r;   v.stall = s; v.av = av; v.ard = ard; v.ad = ad;
        v.mv = mv;   v.mrd = mrd; v.md = md; v.chk_rdy = cr; v.ar = ar; v.mr = mr;
        v.we = we;   v.wr = wr;   v.wd = wd; v.pend = pend;
        return v;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(logic r, logic s, logic av, logic [4:0] ard, logic [63:0] ad,
                         logic mv, logic [4:0] mrd, logic [63:0] md);
        rst = r; wb_stall = s; alu_valid = av; alu_rd = ard; alu_data = ad;
        mem_valid = mv; mem_rd = mrd; mem_data = md;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        fwd_reg = 5'd0;
        drive(1'b0, 1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);

        // rst stall av ard ad mv mrd md chk ar mr | we wr wd pend
        vecs[0]  = mk(0, 0, 0, 0, 0, 1, 1, 64'h9, 0, 0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(0, 0, 0, 0, 0, 1, 1, 64'h9, 1, 0, 1, 0, 0, 0, 0);
        vecs[2]  = mk(1, 0, 0, 0, 0, 1, 1, 64'h9, 1, 0, 1, 0, 0, 0, 1);
        vecs[3]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 64'h9, 0);
        vecs[4]  = mk(1, 0, 1, 5, 64'h0123_4567_89AB_CDEF, 0, 0, 0, 1, 1, 1, 0, 1, 64'h9, 1);
        vecs[5]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 5, 64'h0123_4567_89AB_CDEF, 0);
        vecs[6]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 5, 64'h0123_4567_89AB_CDEF, 0);
        vecs[7]  = mk(1, 0, 1, 4, 64'hBB, 1, 3, 64'hAA, 1, 0, 1, 0, 5,
                      64'h0123_4567_89AB_CDEF, 1);
        vecs[8]  = mk(1, 0, 1, 4, 64'hBB, 0, 0, 0, 1, 1, 1, 1, 3, 64'hAA, 1);
        vecs[9]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 4, 64'hBB, 0);
        vecs[10] = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 4, 64'hBB, 0);
        for (int i = 0; i < 4; i++)
            vecs[11+i] = mk(1, 1, 1, 5'(10 + i), 64'h100 + 64'(i), 0, 0, 0, 1, 1, 1,
                            0, 4, 64'hBB, 3'(i + 1));
        vecs[15] = mk(1, 1, 1, 14, 64'h104, 0, 0, 0, 1, 0, 0, 0, 4, 64'hBB, 4);
        vecs[16] = mk(1, 0, 1, 14, 64'h104, 0, 0, 0, 1, 0, 0, 1, 10, 64'h100, 3);
        vecs[17] = mk(1, 0, 1, 14, 64'h104, 0, 0, 0, 1, 1, 1, 1, 11, 64'h101, 3);
        vecs[18] = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 12, 64'h102, 2);
        vecs[19] = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 13, 64'h103, 1);
        vecs[20] = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 14, 64'h104, 0);
        vecs[21] = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 14, 64'h104, 0);
        for (int i = 0; i < 3; i++)
            vecs[22+i] = mk(1, 1, 1, 5'(20 + i), 64'h200 + 64'(i), 0, 0, 0, 1, 1, 1,
                            0, 14, 64'h104, 3'(i + 1));
        vecs[25] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0);
        vecs[26] = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0);
        vecs[27] = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0);

        #1;
        for (int i = 0; i < 28; i++) begin
            drive(vecs[i].rst, vecs[i].stall, vecs[i].av, vecs[i].ard, vecs[i].ad,
                  vecs[i].mv, vecs[i].mrd, vecs[i].md);
            #1;
            if (vecs[i].chk_rdy) begin
                chk($sformatf("v%0d alu_ready", i), 64'(alu_ready), 64'(vecs[i].ar));
                chk($sformatf("v%0d mem_ready", i), 64'(mem_ready), 64'(vecs[i].mr));
            end
            step();
            chk($sformatf("v%0d RegWrite", i), 64'(RegWrite), 64'(vecs[i].we));
            chk($sformatf("v%0d write_reg", i), 64'(write_reg), 64'(vecs[i].wr));
            chk($sformatf("v%0d write_data", i), write_data, vecs[i].wd);
            chk($sformatf("v%0d pending", i), 64'(pending), 64'(vecs[i].pend));
        end

        // Forwarding: two pending writes to r7, newest must win, then drain through output reg
        drive(1'b1, 1'b1, 1'b1, 5'd7, 64'h11, 1'b0, 5'd0, 64'd0);
        step();
        drive(1'b1, 1'b1, 1'b1, 5'd7, 64'h22, 1'b0, 5'd0, 64'd0);
        step();
        drive(1'b1, 1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
        fwd_reg = 5'd7;
        #1;
        chk("fwd r7 hit", 64'(fwd_hit), 64'(Fwd));
        chk("fwd r7 data", fwd_data, Fwd ? 64'h22 : 64'h0);
        fwd_reg = 5'd9;
        #1;
        chk("fwd r9 hit", 64'(fwd_hit), 64'h0);
        chk("fwd r9 data", fwd_data, 64'h0);
        fwd_reg = 5'd7;
        wb_stall = 1'b0;
        step();
        chk("fwd drain1 we", 64'(RegWrite), 64'h1);
        chk("fwd drain1 data", write_data, 64'h11);
        chk("fwd drain1 hit", 64'(fwd_hit), 64'(Fwd));
        chk("fwd drain1 fdata", fwd_data, Fwd ? 64'h22 : 64'h0);
        step();
        chk("fwd outreg data", write_data, 64'h22);
        chk("fwd outreg hit", 64'(fwd_hit), 64'(Fwd));
        chk("fwd outreg fdata", fwd_data, Fwd ? 64'h22 : 64'h0);
        step();
        chk("fwd idle we", 64'(RegWrite), 64'h0);
        chk("fwd idle hit", 64'(fwd_hit), 64'h0);
        chk("fwd idle fdata", fwd_data, 64'h0);
        chk("fwd idle pending", 64'(pending), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
